// File: rtl/player_missile.sv
`default_nettype none
// ============================================================================
// Module   : player_missile
// Brief    : Player missile launch/flight controller with 24-way enemy hit
//            detection, one-frame collision pulses and a saturating kill count.
// Revision : 1.0 - initial release
// ============================================================================
module player_missile #(
    parameter int MISSILE_SPEED   = 4,
    parameter int NOSE_OFFSET     = 8,
    parameter int TOP_LIMIT       = 8,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ENEMY_HALF      = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fire,
    input  logic       level,
    input  logic       lost_game,
    input  logic [9:0] ship_posX,
    input  logic [9:0] ship_posY,
    input  logic [9:0] enemy_posX [0:23],
    input  logic [9:0] enemy_posY [0:23],
    input  logic       enemy_present [0:23],
    output logic [9:0] missile_posX,
    output logic [9:0] missile_posY,
    output logic       missile_active,
    output logic       enemy_missile_collision [0:23],
    output logic [4:0] kill_count,
    output logic       all_cleared
);

    localparam int          c_NUM_ENEMIES = 24;
    localparam int          c_CW          = (COOLDOWN_FRAMES > 2) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [c_CW-1:0] c_COOL_LOAD = c_CW'(COOLDOWN_FRAMES - 1);
    localparam logic [4:0]  c_KILL_MAX    = 5'd24;
    localparam logic [10:0] c_HALF        = 11'(ENEMY_HALF);
    localparam logic [10:0] c_HALF_M1     = 11'(ENEMY_HALF - 1);
    localparam logic [10:0] c_TOP_ROW     = 11'(TOP_LIMIT + MISSILE_SPEED);

    localparam logic [1:0]  c_IDLE        = 2'd0;
    localparam logic [1:0]  c_FLIGHT      = 2'd1;
    localparam logic [1:0]  c_COOLDOWN    = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_fire_q;
    logic [9:0]      r_pos_x;
    logic [9:0]      r_pos_y;
    logic [9:0]      w_pos_x_next;
    logic [9:0]      w_pos_y_next;
    logic [c_CW-1:0] r_cool;
    logic [c_CW-1:0] w_cool_next;
    logic [23:0]     r_coll;
    logic [23:0]     w_coll_next;
    logic [4:0]      r_kill;
    logic [4:0]      w_kill_next;
    logic            r_active;
    logic            r_all_cleared;

    logic            w_run;
    logic            w_fire_edge;
    logic            w_at_top;
    logic [10:0]     w_mx;
    logic [10:0]     w_my;
    logic [23:0]     w_hit;
    logic [23:0]     w_hit_first;
    logic            w_any_hit;

    assign w_run       = level & ~lost_game;
    assign w_fire_edge = fire & ~r_fire_q;
    assign w_mx        = {1'b0, r_pos_x};
    assign w_my        = {1'b0, r_pos_y};
    assign w_at_top    = (w_my < c_TOP_ROW);

    // 11-bit box test so that enemies near the screen edges never wrap.
    for (genvar k = 0; k < c_NUM_ENEMIES; k++) begin : g_hit
        logic [10:0] w_ex;
        logic [10:0] w_ey;
        assign w_ex     = {1'b0, enemy_posX[k]};
        assign w_ey     = {1'b0, enemy_posY[k]};
        assign w_hit[k] = enemy_present[k]
                        && (w_mx + c_HALF >= w_ex) && (w_mx <= w_ex + c_HALF_M1)
                        && (w_my + c_HALF >= w_ey) && (w_my <= w_ey + c_HALF_M1);
    end

    // Only the lowest-indexed enemy is credited when boxes overlap.
    always_comb begin
        w_hit_first = '0;
        w_any_hit   = 1'b0;
        for (int k = 0; k < c_NUM_ENEMIES; k++) begin
            if (w_hit[k] && !w_any_hit) begin
                w_hit_first[k] = 1'b1;
                w_any_hit      = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_run && w_fire_edge) w_state_next = c_FLIGHT;
            end
            c_FLIGHT: begin
                if (!w_run)                     w_state_next = c_IDLE;
                else if (w_any_hit || w_at_top) w_state_next = c_COOLDOWN;
            end
            c_COOLDOWN: begin
                if (!w_run || (r_cool == '0)) w_state_next = c_IDLE;
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_pos_x_next = r_pos_x;
        w_pos_y_next = r_pos_y;
        w_cool_next  = r_cool;
        w_coll_next  = '0;
        w_kill_next  = r_kill;
        case (r_state)
            c_IDLE: begin
                if (w_run && w_fire_edge) begin
                    w_pos_x_next = ship_posX;
                    w_pos_y_next = ship_posY - 10'(NOSE_OFFSET);
                end
            end
            c_FLIGHT: begin
                if (w_run) begin
                    if (w_any_hit) begin
                        w_coll_next = w_hit_first;
                        w_kill_next = (r_kill == c_KILL_MAX) ? r_kill : r_kill + 5'd1;
                        w_cool_next = c_COOL_LOAD;
                    end else if (w_at_top) begin
                        w_cool_next = c_COOL_LOAD;
                    end else begin
                        w_pos_y_next = r_pos_y - 10'(MISSILE_SPEED);
                    end
                end
            end
            c_COOLDOWN: begin
                if (w_run && (r_cool != '0)) w_cool_next = r_cool - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_fire_q      <= 1'b0;
            r_pos_x       <= '0;
            r_pos_y       <= '0;
            r_cool        <= '0;
            r_coll        <= '0;
            r_kill        <= '0;
            r_active      <= 1'b0;
            r_all_cleared <= 1'b0;
        end else begin
            r_fire_q      <= fire;
            r_pos_x       <= w_pos_x_next;
            r_pos_y       <= w_pos_y_next;
            r_cool        <= w_cool_next;
            r_coll        <= w_coll_next;
            r_kill        <= w_kill_next;
            r_active      <= (w_state_next == c_FLIGHT);
            r_all_cleared <= (w_kill_next == c_KILL_MAX);
        end
    end

    assign missile_posX   = r_pos_x;
    assign missile_posY   = r_pos_y;
    assign missile_active = r_active;
    assign kill_count     = r_kill;
    assign all_cleared    = r_all_cleared;

    for (genvar k = 0; k < c_NUM_ENEMIES; k++) begin : g_coll
        assign enemy_missile_collision[k] = r_coll[k];
    end

endmodule
`default_nettype wire

// File: tb/tb_player_missile.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_missile
// Brief    : Directed self-checking bench for player_missile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_missile;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       fire;
    logic       level;
    logic       lost_game;
    logic [9:0] ship_posX;
    logic [9:0] ship_posY;
    logic [9:0] enemy_posX [0:23];
    logic [9:0] enemy_posY [0:23];
    logic       enemy_present [0:23];
    logic [9:0] missile_posX;
    logic [9:0] missile_posY;
    logic       missile_active;
    logic       enemy_missile_collision [0:23];
    logic [4:0] kill_count;
    logic       all_cleared;

    int          vectors     = 0;
    int          miscompares = 0;
    int          pulse_total = 0;
    int          launches    = 0;
    logic        prev_active = 1'b0;
    logic [23:0] coll_vec;

    player_missile dut (
        .frame_clk               (frame_clk),
        .Reset                   (Reset),
        .fire                    (fire),
        .level                   (level),
        .lost_game               (lost_game),
        .ship_posX               (ship_posX),
        .ship_posY               (ship_posY),
        .enemy_posX              (enemy_posX),
        .enemy_posY              (enemy_posY),
        .enemy_present           (enemy_present),
        .missile_posX            (missile_posX),
        .missile_posY            (missile_posY),
        .missile_active          (missile_active),
        .enemy_missile_collision (enemy_missile_collision),
        .kill_count              (kill_count),
        .all_cleared             (all_cleared)
    );

    always #5 frame_clk = ~frame_clk;

    always_comb begin
        coll_vec = '0;
        for (int k = 0; k < 24; k++) coll_vec[k] = enemy_missile_collision[k];
    end

    // Running tallies of collision pulses and launches, sampled mid-frame.
    always @(negedge frame_clk) begin
        pulse_total <= pulse_total + $countones(coll_vec);
        if (missile_active && !prev_active) launches <= launches + 1;
        prev_active <= missile_active;
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_enemy(input int k, input int x, input int y, input logic p);
        enemy_posX[k]    = 10'(x);
        enemy_posY[k]    = 10'(y);
        enemy_present[k] = p;
    endtask

    task automatic test_reset();
        vectors++; if (missile_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %0b expected 0", missile_active); end
        vectors++; if (missile_posX !== 10'd0) begin miscompares++; $display("FAIL reset_posX: got %0d expected 0", missile_posX); end
        vectors++; if (missile_posY !== 10'd0) begin miscompares++; $display("FAIL reset_posY: got %0d expected 0", missile_posY); end
        vectors++; if (coll_vec !== 24'h0) begin miscompares++; $display("FAIL reset_coll: got %h expected 000000", coll_vec); end
        vectors++; if (kill_count !== 5'd0) begin miscompares++; $display("FAIL reset_kill: got %0d expected 0", kill_count); end
        vectors++; if (all_cleared !== 1'b0) begin miscompares++; $display("FAIL reset_cleared: got %0b expected 0", all_cleared); end
    endtask

    task automatic test_launch();
        level = 1'b1; ship_posX = 10'd100; ship_posY = 10'd400;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_active !== 1'b1) begin miscompares++; $display("FAIL launch_active: got %0b expected 1", missile_active); end
        vectors++; if (missile_posX !== 10'd100) begin miscompares++; $display("FAIL launch_posX: got %0d expected 100", missile_posX); end
        vectors++; if (missile_posY !== 10'd392) begin miscompares++; $display("FAIL launch_posY: got %0d expected 392", missile_posY); end
        repeat (3) tick();
        vectors++; if (missile_posY !== 10'd380) begin miscompares++; $display("FAIL rise_posY: got %0d expected 380", missile_posY); end
        level = 1'b0;
        tick();
        vectors++; if (missile_active !== 1'b0) begin miscompares++; $display("FAIL level_abort_active: got %0b expected 0", missile_active); end
        level = 1'b1;
        tick();
    endtask

    task automatic test_hit_cooldown();
        int p0;
        p0 = pulse_total;
        ship_posX = 10'd100; ship_posY = 10'd80;
        set_enemy(3, 97, 48, 1'b1);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_posY !== 10'd72) begin miscompares++; $display("FAIL hit_launch_posY: got %0d expected 72", missile_posY); end
        repeat (5) tick();
        vectors++; if (missile_posY !== 10'd52 || coll_vec !== 24'h0) begin miscompares++; $display("FAIL hit_prehit: got posY=%0d coll=%h expected posY=52 coll=000000", missile_posY, coll_vec); end
        tick();
        vectors++; if (coll_vec !== 24'h000008) begin miscompares++; $display("FAIL hit_pulse: got %h expected 000008", coll_vec); end
        vectors++; if (kill_count !== 5'd1) begin miscompares++; $display("FAIL hit_kill: got %0d expected 1", kill_count); end
        vectors++; if (missile_active !== 1'b0 || missile_posY !== 10'd52) begin miscompares++; $display("FAIL hit_hold: got active=%0b posY=%0d expected active=0 posY=52", missile_active, missile_posY); end
        enemy_present[3] = 1'b0;
        tick();
        vectors++; if (coll_vec !== 24'h0) begin miscompares++; $display("FAIL hit_pulse_width: got %h expected 000000", coll_vec); end
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_active !== 1'b0) begin miscompares++; $display("FAIL cooldown_fire_early: got %0b expected 0", missile_active); end
        repeat (5) tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_active !== 1'b0) begin miscompares++; $display("FAIL cooldown_fire_last: got %0b expected 0", missile_active); end
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_active !== 1'b1 || missile_posY !== 10'd72) begin miscompares++; $display("FAIL relaunch: got active=%0b posY=%0d expected active=1 posY=72", missile_active, missile_posY); end
        vectors++; if (pulse_total - p0 !== 1) begin miscompares++; $display("FAIL hit_pulse_count: got %0d expected 1", pulse_total - p0); end
        level = 1'b0;
        tick();
        level = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        ship_posX = 10'd100; ship_posY = 10'd80;
        set_enemy(8, 100, 44, 1'b1);
        set_enemy(9, 104, 44, 1'b1);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (6) tick();
        vectors++; if (missile_posY !== 10'd48 || coll_vec !== 24'h0) begin miscompares++; $display("FAIL prio_prehit: got posY=%0d coll=%h expected posY=48 coll=000000", missile_posY, coll_vec); end
        tick();
        vectors++; if (coll_vec !== 24'h000100) begin miscompares++; $display("FAIL prio_pulse: got %h expected 000100", coll_vec); end
        vectors++; if (kill_count !== 5'd2) begin miscompares++; $display("FAIL prio_kill: got %0d expected 2", kill_count); end
        enemy_present[8] = 1'b0;
        tick();
        repeat (7) tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_active !== 1'b1) begin miscompares++; $display("FAIL prio_earliest_relaunch: got %0b expected 1", missile_active); end
        repeat (7) tick();
        vectors++; if (coll_vec !== 24'h000200 || kill_count !== 5'd3) begin miscompares++; $display("FAIL prio_second_hit: got coll=%h kill=%0d expected coll=000200 kill=3", coll_vec, kill_count); end
        enemy_present[9] = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_miss();
        int p0;
        p0 = pulse_total;
        ship_posX = 10'd43; ship_posY = 10'd40;
        set_enemy(0, 43, 20, 1'b0);
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vectors++; if (missile_posY !== 10'd32) begin miscompares++; $display("FAIL miss_launch_posY: got %0d expected 32", missile_posY); end
        repeat (6) tick();
        vectors++; if (missile_active !== 1'b1 || missile_posY !== 10'd8) begin miscompares++; $display("FAIL miss_top_row: got active=%0b posY=%0d expected active=1 posY=8", missile_active, missile_posY); end
        tick();
        vectors++; if (missile_active !== 1'b0 || missile_posY !== 10'd8) begin miscompares++; $display("FAIL miss_retire: got active=%0b posY=%0d expected active=0 posY=8", missile_active, missile_posY); end
        tick();
        vectors++; if (pulse_total - p0 !== 0 || kill_count !== 5'd3) begin miscompares++; $display("FAIL miss_no_kill: got pulses=%0d kill=%0d expected pulses=0 kill=3", pulse_total - p0, kill_count); end
        repeat (10) tick();
    endtask

    task automatic test_hold_fire();
        int l0;
        l0 = launches;
        ship_posX = 10'd100; ship_posY = 10'd400;
        fire = 1'b1;
        repeat (50) tick();
        vectors++; if (launches - l0 !== 1 || missile_active !== 1'b1) begin miscompares++; $display("FAIL hold_fire: got launches=%0d active=%0b expected launches=1 active=1", launches - l0, missile_active); end
    endtask

    task automatic test_lost_game();
        int p0;
        p0 = pulse_total;
        lost_game = 1'b1;
        tick();
        vectors++; if (missile_active !== 1'b0 || coll_vec !== 24'h0 || kill_count !== 5'd3) begin miscompares++; $display("FAIL lost_game_abort: got active=%0b coll=%h kill=%0d expected active=0 coll=000000 kill=3", missile_active, coll_vec, kill_count); end
        lost_game = 1'b0;
        fire      = 1'b0;
        repeat (2) tick();
        vectors++; if (pulse_total - p0 !== 0) begin miscompares++; $display("FAIL lost_game_pulses: got %0d expected 0", pulse_total - p0); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_coll;
        logic [4:0]  exp_kill;
        ship_posX = 10'd100; ship_posY = 10'd80;
        for (int k = 0; k < 24; k++) set_enemy(k, 100, 64, 1'b1);
        for (int k = 0; k < 24; k++) begin
            exp_coll = 24'd1 << k;
            exp_kill = (k + 4 > 24) ? 5'd24 : 5'(k + 4);
            fire = 1'b1;
            tick();
            fire = 1'b0;
            repeat (2) tick();
            vectors++; if (coll_vec !== exp_coll || kill_count !== exp_kill || all_cleared !== (exp_kill == 5'd24)) begin
                miscompares++;
                $display("FAIL b2b_hit_%0d: got coll=%h kill=%0d cleared=%0b expected coll=%h kill=%0d cleared=%0b",
                         k, coll_vec, kill_count, all_cleared, exp_coll, exp_kill, (exp_kill == 5'd24));
            end
            enemy_present[k] = 1'b0;
            repeat (9) tick();
        end
        vectors++; if (kill_count !== 5'd24 || all_cleared !== 1'b1) begin miscompares++; $display("FAIL b2b_final: got kill=%0d cleared=%0b expected kill=24 cleared=1", kill_count, all_cleared); end
    endtask

    task automatic test_reset_midflight();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
        vectors++; if (missile_active !== 1'b1) begin miscompares++; $display("FAIL midflight_launch: got %0b expected 1", missile_active); end
        #2 Reset = 1'b1;
        #1;
        vectors++; if (missile_active !== 1'b0 || kill_count !== 5'd0 || all_cleared !== 1'b0 || coll_vec !== 24'h0) begin
            miscompares++;
            $display("FAIL async_reset: got active=%0b kill=%0d cleared=%0b coll=%h expected 0 0 0 000000", missile_active, kill_count, all_cleared, coll_vec);
        end
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; fire = 1'b0; level = 1'b0; lost_game = 1'b0;
        ship_posX = '0; ship_posY = '0;
        for (int k = 0; k < 24; k++) set_enemy(k, 0, 0, 1'b0);
        repeat (2) tick();
        test_reset();
        Reset = 1'b0;
        test_launch();
        test_hit_cooldown();
        test_priority();
        test_miss();
        test_hold_fire();
        test_lost_game();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
